// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch controller.
// Provides the FSM state enum and the alignment helper.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    OUT   = 2'd2,
    FAULT = 2'd3
  } fetch_state_e;

  localparam int unsigned INST_BYTES = 32'd4;
  localparam logic [1:0]  ALIGN_MASK = 2'b11;

  // A fetch address is legal only when its low bits are clear under ALIGN_MASK.
  function automatic logic pc_misaligned(input logic [1:0] pc_lo);
    return |(pc_lo & ALIGN_MASK);
  endfunction

endpackage

// File: rtl/fetch_ctrl.sv
// Instruction-fetch FSM: requests a word at current_pc, holds it for decode,
// and drives the PC register's update port on accept or redirect.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [XLEN-1:0] current_pc,
  output logic            pc_write,
  output logic [XLEN-1:0] next_pc,
  output logic            mem_req,
  output logic [XLEN-1:0] mem_addr,
  input  logic            mem_ready,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst_data,
  output logic [XLEN-1:0] inst_pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  output logic            fetch_fault
);

  fetch_state_e    state_r;
  logic [XLEN-1:0] inst_data_r;
  logic [XLEN-1:0] inst_pc_r;
  logic            fault_r;

  logic            misaligned_s;
  logic            pc_write_s;
  logic [XLEN-1:0] next_pc_s;
  logic            mem_req_s;
  logic            inst_valid_s;

  assign misaligned_s = pc_misaligned(current_pc[1:0]);

  // Same-cycle PC update and handshake qualifiers; redirect outranks everything.
  always_comb begin
    pc_write_s   = 1'b0;
    next_pc_s    = '0;
    mem_req_s    = 1'b0;
    inst_valid_s = 1'b0;
    if (reset) begin
      pc_write_s = 1'b0;
    end else begin
      case (state_r)
        IDLE, REQ, OUT: begin
          if (redirect_valid) begin
            pc_write_s = 1'b1;
            next_pc_s  = redirect_target;
          end else if (state_r == REQ) begin
            mem_req_s = !misaligned_s;
          end else if (state_r == OUT) begin
            inst_valid_s = 1'b1;
            if (inst_ready) begin
              pc_write_s = 1'b1;
              next_pc_s  = current_pc + XLEN'(INST_BYTES);
            end else begin
              pc_write_s = 1'b0;
            end
          end else begin
            pc_write_s = 1'b0;
          end
        end
        default: begin
          pc_write_s = 1'b0;
        end
      endcase
    end
  end

  // FSM state, instruction holding register and sticky fault flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      inst_data_r <= '0;
      inst_pc_r   <= '0;
      fault_r     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: state_r <= REQ;
        REQ: begin
          if (redirect_valid) begin
            state_r <= REQ;
          end else if (misaligned_s) begin
            state_r     <= FAULT;
            fault_r     <= 1'b1;
            inst_data_r <= '0;
            inst_pc_r   <= '0;
          end else if (mem_ready) begin
            state_r     <= OUT;
            inst_data_r <= mem_rdata;
            inst_pc_r   <= current_pc;
          end
        end
        OUT: begin
          if (redirect_valid || inst_ready) begin
            state_r <= REQ;
          end
        end
        FAULT: state_r <= FAULT;
        default: state_r <= IDLE;
      endcase
    end
  end

  assign pc_write    = pc_write_s;
  assign next_pc     = next_pc_s;
  assign mem_req     = mem_req_s;
  assign mem_addr    = mem_req_s ? current_pc : '0;
  assign inst_valid  = inst_valid_s;
  assign inst_data   = inst_data_r;
  assign inst_pc     = inst_pc_r;
  assign fetch_fault = fault_r;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl with a behavioural PC register and memory.
module tb_fetch_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] current_pc;
  logic        pc_write;
  logic [31:0] next_pc;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        fetch_fault;

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] pc;
  } sb_entry_t;

  sb_entry_t   sb_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          phase;
  logic [31:0] exp_pc;

  fetch_ctrl #(.XLEN(32)) dut (
    .clock          (clock),
    .reset          (reset),
    .current_pc     (current_pc),
    .pc_write       (pc_write),
    .next_pc        (next_pc),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_ready      (mem_ready),
    .mem_rdata      (mem_rdata),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .fetch_fault    (fetch_fault)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a << 8) ^ 32'h0000_0013;
  endfunction

  // PC register beside the controller
  always_ff @(posedge clock or posedge reset) begin
    if (reset) current_pc <= 32'd0;
    else if (pc_write) current_pc <= next_pc;
  end

  assign mem_rdata = mem_ready ? mem_word(mem_addr) : 32'hDEAD_BEEF;

  task automatic check_value(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // phase: 0 idle, 1 request outstanding, 2 instruction held for decode
  task automatic run_cycle(input logic rdy, input logic irdy, input logic rv, input logic [31:0] tgt);
    sb_entry_t e;
    mem_ready       = rdy;
    inst_ready      = irdy;
    redirect_valid  = rv;
    redirect_target = tgt;
    #1;
    check_value("inst_valid", {31'd0, inst_valid}, {31'd0, (phase == 2) && !rv});
    check_value("fetch_fault", {31'd0, fetch_fault}, 32'd0);
    if (phase == 1 && !rv) begin
      check_value("mem_req", {31'd0, mem_req}, 32'd1);
      check_value("mem_addr", mem_addr, exp_pc);
    end else if (!rv) begin
      check_value("mem_req_idle", {31'd0, mem_req}, 32'd0);
    end
    if (rv) begin
      check_value("redir_pc_write", {31'd0, pc_write}, 32'd1);
      check_value("redir_next_pc", next_pc, tgt);
      if (phase == 2 && sb_q.size() > 0) void'(sb_q.pop_front());
      exp_pc = tgt;
      phase  = 1;
    end else begin
      case (phase)
        0: begin
          check_value("idle_pc_write", {31'd0, pc_write}, 32'd0);
          phase = 1;
        end
        1: begin
          check_value("req_pc_write", {31'd0, pc_write}, 32'd0);
          if (rdy) begin
            sb_q.push_back('{data: mem_word(exp_pc), pc: exp_pc});
            phase = 2;
          end
        end
        default: begin
          check_value("sb_nonempty", {31'd0, sb_q.size() > 0}, 32'd1);
          if (sb_q.size() > 0) begin
            e = sb_q[0];
            check_value("inst_data", inst_data, e.data);
            check_value("inst_pc", inst_pc, e.pc);
            if (irdy) begin
              void'(sb_q.pop_front());
              check_value("acc_pc_write", {31'd0, pc_write}, 32'd1);
              check_value("acc_next_pc", next_pc, e.pc + 32'd4);
              exp_pc = e.pc + 32'd4;
              phase  = 1;
            end else begin
              check_value("stall_pc_write", {31'd0, pc_write}, 32'd0);
            end
          end
        end
      endcase
    end
    @(negedge clock);
  endtask

  initial begin
    reset = 1'b1;
    mem_ready = 1'b0;
    inst_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_target = 32'd0;
    phase = 0;
    exp_pc = 32'd0;
    #2;
    check_value("rst_pc_write", {31'd0, pc_write}, 32'd0);
    check_value("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check_value("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    check_value("rst_fault", {31'd0, fetch_fault}, 32'd0);
    check_value("rst_inst_data", inst_data, 32'd0);
    check_value("rst_inst_pc", inst_pc, 32'd0);
    check_value("rst_next_pc", next_pc, 32'd0);
    check_value("rst_mem_addr", mem_addr, 32'd0);
    @(negedge clock);
    reset = 1'b0;

    // reset then fetch at 0
    run_cycle(1'b0, 1'b0, 1'b0, 32'd0);
    run_cycle(1'b1, 1'b1, 1'b0, 32'd0);
    run_cycle(1'b0, 1'b1, 1'b0, 32'd0);

    // memory wait then decode stall
    repeat (3) run_cycle(1'b0, 1'b1, 1'b0, 32'd0);
    run_cycle(1'b1, 1'b0, 1'b0, 32'd0);
    repeat (4) run_cycle(1'b0, 1'b0, 1'b0, 32'd0);
    run_cycle(1'b0, 1'b1, 1'b0, 32'd0);

    // redirect cancels request, then redirect beats accept
    run_cycle(1'b1, 1'b0, 1'b1, 32'h0000_0100);
    run_cycle(1'b1, 1'b0, 1'b0, 32'd0);
    run_cycle(1'b0, 1'b1, 1'b1, 32'h0000_0200);
    run_cycle(1'b1, 1'b1, 1'b0, 32'd0);
    run_cycle(1'b0, 1'b1, 1'b0, 32'd0);

    // wrap-around from the top word of the address space
    run_cycle(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    run_cycle(1'b1, 1'b0, 1'b0, 32'd0);
    run_cycle(1'b0, 1'b1, 1'b0, 32'd0);
    check_value("wrap_exp_pc", exp_pc, 32'd0);

    for (int i = 0; i < 24; i++) begin
      run_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 32'd0);
    end
    if (phase == 2) run_cycle(1'b0, 1'b1, 1'b0, 32'd0);

    // misaligned redirect: accepted, then fault on the following REQ
    run_cycle(1'b0, 1'b0, 1'b1, 32'h0000_0102);
    mem_ready = 1'b1;
    inst_ready = 1'b0;
    redirect_valid = 1'b0;
    #1;
    check_value("mis_mem_req", {31'd0, mem_req}, 32'd0);
    check_value("mis_pc_write", {31'd0, pc_write}, 32'd0);
    @(negedge clock);
    for (int i = 0; i < 3; i++) begin
      mem_ready = 1'b1;
      inst_ready = 1'b1;
      redirect_valid = 1'b1;
      redirect_target = 32'h0000_0300;
      #1;
      check_value("flt_fault", {31'd0, fetch_fault}, 32'd1);
      check_value("flt_mem_req", {31'd0, mem_req}, 32'd0);
      check_value("flt_pc_write", {31'd0, pc_write}, 32'd0);
      check_value("flt_next_pc", next_pc, 32'd0);
      check_value("flt_inst_valid", {31'd0, inst_valid}, 32'd0);
      check_value("flt_inst_data", inst_data, 32'd0);
      check_value("flt_mem_addr", mem_addr, 32'd0);
      @(negedge clock);
    end

    // asynchronous reset clears the fault immediately
    redirect_valid = 1'b0;
    reset = 1'b1;
    #1;
    check_value("arst_fault", {31'd0, fetch_fault}, 32'd0);
    check_value("arst_pc_write", {31'd0, pc_write}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    phase = 0;
    exp_pc = 32'd0;
    sb_q.delete();
    run_cycle(1'b0, 1'b0, 1'b0, 32'd0);
    run_cycle(1'b1, 1'b1, 1'b0, 32'd0);
    run_cycle(1'b0, 1'b1, 1'b0, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
